perf_engine_sequencer: RTL and testbench
========================================

# perf_engine_sequencer

Sequences the read and write AXI master engines of the HDL performance-test action. From one register-level start, it issues `engine_start_pulse` to the read and/or write master according to a run mode and repeats the run a programmed number of times. It collects done pulses and error codes from both engines, accumulates per-direction busy-cycle counters for bandwidth calculation, and reports one completion pulse with sticky status to the action register file.

## Interface
- `CNT_WIDTH`, 48: width of the cycle counters.
- `TO_WIDTH`, 32: width of the watchdog counter and limit.

- `clk` in 1: single clock.
- `rst` in 1: synchronous reset, active-high.
- `start_pulse` in 1: one-cycle run request from registers.
- `mode` in 2: 0 = read only, 1 = write only, 2 = concurrent, 3 = write then read.
- `repeat_num` in 16: iterations; 0 is treated as 1.
- `rd_number` in 32: burst count configured in the read master; 0 means that direction is skipped.
- `wr_number` in 32: burst count configured in the write master; 0 means that direction is skipped.
- `timeout_limit` in TO_WIDTH: watchdog cycles per iteration; 0 disables the watchdog.
- `rd_done_pulse`, `wr_done_pulse` in 1: done pulses from the masters.
- `rd_error`, `wr_error` in 2: error codes from the masters, sampled on their done pulse.
- `rd_start_pulse`, `wr_start_pulse` out 1: connect to each master's `engine_start_pulse`.
- `busy` out 1: a run is in progress.
- `done_pulse` out 1: one cycle at run end.
- `status` out 5: {timeout, wr_error, rd_error}, sticky until the next start.
- `iter_count` out 16: number of completed iterations.
- `rd_cycles`, `wr_cycles`, `total_cycles` out CNT_WIDTH: accumulated cycle counts.

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, FINISH.
- IDLE, on `start_pulse`:
  - clear `status`, `iter_count` and all counters;
  - latch `mode`, `repeat_num`, `rd_number != 0` (rd_en) and `wr_number != 0` (wr_en);
  - go to ISSUE.
- ISSUE issues launches, then goes to WAIT:
  - mode 0: `rd_start_pulse` if rd_en;
  - mode 1: `wr_start_pulse` if wr_en;
  - mode 2: both pulses, each gated by its enable, in the same cycle;
  - mode 3: write phase first (`wr_start_pulse` if wr_en); the read phase is entered from WAIT.
  - If nothing is launched (direction disabled), go directly to NEXT.
- WAIT:
  - Per-direction pending flags set on launch and clear on the matching done pulse, which also ORs that master's error into `status`.
  - When all flags are clear, go to NEXT.
  - Mode 3 exception: when the write phase completes and rd_en is set, pulse `rd_start_pulse` and remain in WAIT.
- NEXT:
  - increment `iter_count`;
  - if `iter_count` has reached the effective repeat count, or `status[3:0]` is nonzero (abort on error), go to FINISH;
  - otherwise go to ISSUE.
- FINISH: assert `done_pulse`, go to IDLE.
- `start_pulse` while `busy` is ignored.
- Done pulses arriving outside WAIT, or for a direction that is not pending, are ignored.
- `rd_done_pulse` and `wr_done_pulse` in the same cycle are both accepted.
- Counters:
  - `total_cycles` increments every cycle `busy`=1;
  - `rd_cycles` increments every cycle the read direction is pending, including its done cycle; `wr_cycles` likewise for write;
  - all counters saturate at their maximum value and never wrap.
- `rst` mid-run returns the block to IDLE and zeroes every output. In-flight masters are not aborted; their later done pulses are ignored.

## Timing
- Reset value of every output is 0.
- `start_pulse` at cycle T: `busy`=1 and ISSUE at T+1; start pulses asserted at T+1; WAIT at T+2.
- Launch pulses are exactly one cycle wide.
- Done pulse at cycle D (last pending direction): NEXT at D+1, then ISSUE at D+2 or FINISH at D+2.
- `done_pulse` is asserted at FINISH; `busy` falls the following cycle.
- A run with both directions disabled has `busy` high for 3 cycles: ISSUE, NEXT, FINISH.
- Mode 3 read-launch latency: write done at D, `rd_start_pulse` at D+1.

## Configuration
- `PERF_SEQ_TIMEOUT_EN` defined:
  - a watchdog counts cycles in WAIT and clears in ISSUE;
  - when it reaches a nonzero `timeout_limit`, the block sets `status[4]` and goes to FINISH next cycle, ignoring pending flags.
- `PERF_SEQ_TIMEOUT_EN` undefined:
  - no watchdog logic is built;
  - `status[4]` is tied to 0;
  - `timeout_limit` is unused.

## Structure
- Shared package `perf_seq_pkg` holds:
  - the state enum;
  - mode encodings `MODE_RD`, `MODE_WR`, `MODE_CONC`, `MODE_WR_RD`;
  - the status bit-index constants.
- One sub-module, `sat_counter`: a parameterized saturating counter with clear and enable, used for the three cycle counters and the watchdog.

## Test plan
- Mode 0 read only:
  - stimulus: `rd_number`=4, `repeat_num`=1, `rd_done_pulse` 10 cycles after `rd_start_pulse`;
  - required: `rd_cycles`=10, `wr_start_pulse` never asserted, `done_pulse` 2 cycles after the read done, `status`=0.
- Mode 2 concurrent:
  - stimulus: `repeat_num`=3, both done pulses in the same cycle;
  - required: `iter_count`=3, six start pulses total, `status`=0.
- Mode 3 write then read:
  - stimulus: write done at cycle D;
  - required: `rd_start_pulse` at D+1; a read done arriving before the write done is ignored.
- Error abort:
  - stimulus: `repeat_num`=5, `wr_error`=2'b10 on the iteration-2 done pulse;
  - required: stop after 2 iterations, `status`=5'b01000.
- Skip path:
  - stimulus: `rd_number`=`wr_number`=0;
  - required: no launches, `busy` high 3 cycles.
  - stimulus: `start_pulse` while `busy`;
  - required: ignored.
- With `PERF_SEQ_TIMEOUT_EN` defined:
  - stimulus: `timeout_limit`=100, no done pulse;
  - required: `status[4]`=1, `done_pulse` 101 cycles after WAIT entry.
  - stimulus: `rst` mid-run;
  - required: all outputs 0.

Source files
------------

// File: rtl/perf_seq_pkg.sv
// perf_seq_pkg
// Shared definitions for the performance-test engine sequencer:
//   - state_t       : sequencer FSM states
//   - MODE_*        : run-mode encodings seen on the 'mode' register field
//   - ST_*          : bit positions inside the 5-bit sticky status word
//   - first_launch  : which masters are started when an iteration begins
package perf_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam logic [1:0] MODE_RD    = 2'd0;
    localparam logic [1:0] MODE_WR    = 2'd1;
    localparam logic [1:0] MODE_CONC  = 2'd2;
    localparam logic [1:0] MODE_WR_RD = 2'd3;

    // status = {timeout, wr_error[1:0], rd_error[1:0]}
    localparam int ST_RD_LSB  = 0;
    localparam int ST_WR_LSB  = 2;
    localparam int ST_TIMEOUT = 4;
    localparam int ST_WIDTH   = 5;

    // Launch pair {rd, wr} issued at the start of an iteration.
    // Write-then-read starts only the write phase; if the write direction
    // is disabled the read phase is started straight away.
    function automatic logic [1:0] first_launch(input logic [1:0] m,
                                                input logic       rd_en,
                                                input logic       wr_en);
        logic [1:0] l;
        l = 2'b00;
        case (m)
            MODE_RD:    l = {rd_en, 1'b0};
            MODE_WR:    l = {1'b0, wr_en};
            MODE_CONC:  l = {rd_en, wr_en};
            default:    l = wr_en ? 2'b01 : {rd_en, 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-high reset (count -> 0)
//   clr   : synchronous clear (count -> 0), same effect as rst
//   en    : count this cycle
//   count : current value
module sat_counter #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/perf_engine_sequencer.sv
// perf_engine_sequencer
// Drives the engine_start_pulse of the read and write AXI masters of the
// performance-test action. One register start runs 'repeat_num' iterations
// (0 counts as 1) in the selected mode, gathers done pulses / error codes,
// accumulates busy-cycle counters and reports one done_pulse with sticky
// status.
//
// Ports
//   clk, rst                     : clock, synchronous active-high reset
//   start_pulse                  : run request (ignored while busy)
//   mode                         : 0 rd, 1 wr, 2 concurrent, 3 write then read
//   repeat_num                   : iterations per run
//   rd_number, wr_number         : master burst counts, 0 disables a direction
//   timeout_limit                : per-iteration watchdog limit, 0 disables
//   rd_done_pulse, wr_done_pulse : master completion pulses
//   rd_error, wr_error           : master error codes, valid with their done
//   rd_start_pulse, wr_start_pulse : one-cycle master launches
//   busy, done_pulse             : run in progress / run finished
//   status                       : {timeout, wr_error, rd_error}, sticky per run
//   iter_count                   : completed iterations
//   rd_cycles, wr_cycles, total_cycles : saturating cycle counters
//
// Build option
//   PERF_SEQ_TIMEOUT_EN : builds the per-iteration watchdog. Without it the
//   timeout status bit stays 0 and timeout_limit is not used.
module perf_engine_sequencer
    import perf_seq_pkg::*;
#(
    parameter int CNT_WIDTH = 48,
    parameter int TO_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_pulse,
    input  logic [1:0]           mode,
    input  logic [15:0]          repeat_num,
    input  logic [31:0]          rd_number,
    input  logic [31:0]          wr_number,
    input  logic [TO_WIDTH-1:0]  timeout_limit,
    input  logic                 rd_done_pulse,
    input  logic                 wr_done_pulse,
    input  logic [1:0]           rd_error,
    input  logic [1:0]           wr_error,
    output logic                 rd_start_pulse,
    output logic                 wr_start_pulse,
    output logic                 busy,
    output logic                 done_pulse,
    output logic [4:0]           status,
    output logic [15:0]          iter_count,
    output logic [CNT_WIDTH-1:0] rd_cycles,
    output logic [CNT_WIDTH-1:0] wr_cycles,
    output logic [CNT_WIDTH-1:0] total_cycles
);

    state_t      state;
    logic [1:0]  mode_q;
    logic [15:0] rep_q;
    logic        rd_en_q;
    logic        wr_en_q;
    logic        rd_pend;
    logic        wr_pend;

    logic        start_acc;
    logic        rd_fin;
    logic        wr_fin;
    logic        rd_chain;
    logic        last_iter;
    logic        timeout;

    assign start_acc = (state == S_IDLE) && start_pulse;

    // A done pulse only counts for a direction that is actually pending;
    // pending flags are only ever set while in WAIT.
    assign rd_fin = rd_pend && rd_done_pulse;
    assign wr_fin = wr_pend && wr_done_pulse;

    // Write-then-read: the write completion launches the read phase.
    assign rd_chain = wr_fin && (mode_q == MODE_WR_RD) && rd_en_q;

    assign last_iter = (({1'b0, iter_count} + 17'd1) >= {1'b0, rep_q}) ||
                       (status[3:0] != 4'd0);

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef PERF_SEQ_TIMEOUT_EN
    logic [TO_WIDTH-1:0] wd_count;

    sat_counter #(.WIDTH(TO_WIDTH)) u_wd (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == S_ISSUE),
        .en    (state == S_WAIT),
        .count (wd_count)
    );

    assign timeout = (state == S_WAIT) && (timeout_limit != '0) &&
                     (wd_count >= timeout_limit);
`else
    logic unused_timeout_limit;
    assign unused_timeout_limit = ^timeout_limit;
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            mode_q         <= MODE_RD;
            rep_q          <= '0;
            rd_en_q        <= 1'b0;
            wr_en_q        <= 1'b0;
            rd_pend        <= 1'b0;
            wr_pend        <= 1'b0;
            rd_start_pulse <= 1'b0;
            wr_start_pulse <= 1'b0;
            busy           <= 1'b0;
            done_pulse     <= 1'b0;
            status         <= '0;
            iter_count     <= '0;
        end else begin
            rd_start_pulse <= 1'b0;
            wr_start_pulse <= 1'b0;
            done_pulse     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_pulse) begin
                        status     <= '0;
                        iter_count <= '0;
                        mode_q     <= mode;
                        rep_q      <= (repeat_num == 16'd0) ? 16'd1 : repeat_num;
                        rd_en_q    <= (rd_number != 32'd0);
                        wr_en_q    <= (wr_number != 32'd0);
                        busy       <= 1'b1;
                        // Launches are registered here so they coincide
                        // with the ISSUE cycle.
                        {rd_start_pulse, wr_start_pulse} <=
                            first_launch(mode, rd_number != 32'd0, wr_number != 32'd0);
                        state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // Pending starts the cycle after the launch pulse, so a
                    // direction is counted from launch+1 up to its done cycle.
                    rd_pend <= rd_start_pulse;
                    wr_pend <= wr_start_pulse;
                    state   <= (rd_start_pulse || wr_start_pulse) ? S_WAIT : S_NEXT;
                end

                S_WAIT: begin
                    if (rd_start_pulse) begin
                        rd_pend <= 1'b1;
                    end else if (rd_fin) begin
                        rd_pend <= 1'b0;
                        status[ST_RD_LSB +: 2] <= status[ST_RD_LSB +: 2] | rd_error;
                    end

                    if (wr_fin) begin
                        wr_pend <= 1'b0;
                        status[ST_WR_LSB +: 2] <= status[ST_WR_LSB +: 2] | wr_error;
                        if (rd_chain) begin
                            rd_start_pulse <= 1'b1;
                        end
                    end

                    if (timeout) begin
                        // Give up on the iteration; late done pulses from the
                        // masters are ignored because nothing is pending.
                        status[ST_TIMEOUT] <= 1'b1;
                        rd_pend            <= 1'b0;
                        wr_pend            <= 1'b0;
                        rd_start_pulse     <= 1'b0;
                        done_pulse         <= 1'b1;
                        state              <= S_FINISH;
                    end else if (!(rd_pend && !rd_fin) && !(wr_pend && !wr_fin) &&
                                 !rd_start_pulse && !rd_chain) begin
                        state <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    iter_count <= iter_count + 16'd1;
                    if (last_iter) begin
                        done_pulse <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        {rd_start_pulse, wr_start_pulse} <=
                            first_launch(mode_q, rd_en_q, wr_en_q);
                        state <= S_ISSUE;
                    end
                end

                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Cycle counters
    // ------------------------------------------------------------------
    sat_counter #(.WIDTH(CNT_WIDTH)) u_total_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (busy),
        .count (total_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (rd_pend),
        .count (rd_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc),
        .en    (wr_pend),
        .count (wr_cycles)
    );

endmodule

// File: tb/tb_perf_engine_sequencer.sv
// Bench for perf_engine_sequencer. The stimulus process computes, for each
// run, the launches (direction + cycle) and the final report from the
// master delays it chooses, and queues them; emulated masters answer the
// launches; a monitor pops and compares whenever the DUT pulses.
module tb_perf_engine_sequencer;

    localparam int CW = 48;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_pulse = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [15:0]   repeat_num = 16'd0;
    logic [31:0]   rd_number = 32'd0;
    logic [31:0]   wr_number = 32'd0;
    logic [TW-1:0] timeout_limit = '0;
    logic          rd_done_pulse = 1'b0;
    logic          wr_done_pulse = 1'b0;
    logic [1:0]    rd_error = 2'b00;
    logic [1:0]    wr_error = 2'b00;
    logic          rd_start_pulse, wr_start_pulse, busy, done_pulse;
    logic [4:0]    status;
    logic [15:0]   iter_count;
    logic [CW-1:0] rd_cycles, wr_cycles, total_cycles;

    perf_engine_sequencer #(.CNT_WIDTH(CW), .TO_WIDTH(TW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_pulse    (start_pulse),
        .mode           (mode),
        .repeat_num     (repeat_num),
        .rd_number      (rd_number),
        .wr_number      (wr_number),
        .timeout_limit  (timeout_limit),
        .rd_done_pulse  (rd_done_pulse),
        .wr_done_pulse  (wr_done_pulse),
        .rd_error       (rd_error),
        .wr_error       (wr_error),
        .rd_start_pulse (rd_start_pulse),
        .wr_start_pulse (wr_start_pulse),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .status         (status),
        .iter_count     (iter_count),
        .rd_cycles      (rd_cycles),
        .wr_cycles      (wr_cycles),
        .total_cycles   (total_cycles)
    );

    always #5 clk = ~clk;

    // Cycle k = state after the k-th rising edge, observed at the following
    // falling edge; inputs driven at falling edge k belong to cycle k.
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [1:0] dirs;
        int         cyc;
    } launch_t;

    typedef struct {
        logic [4:0] st;
        int         it;
        longint     rdc;
        longint     wrc;
        longint     tot;
        int         cyc;
    } run_t;

    launch_t    exp_l[$];
    run_t       exp_r[$];
    int         rd_dq[$];
    int         wr_dq[$];
    logic [1:0] rd_eq[$];
    logic [1:0] wr_eq[$];
    int         cur_mode = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------
    // Emulated masters
    // ---------------------------------------------------------------
    int         rsp_rd_at = -1;
    int         rsp_wr_at = -1;
    int         rsp_noise_at = -1;
    logic [1:0] rsp_rd_e = 2'b00;
    logic [1:0] rsp_wr_e = 2'b00;

    always @(negedge clk) begin
        if (rst) begin
            rsp_rd_at    = -1;
            rsp_wr_at    = -1;
            rsp_noise_at = -1;
        end else begin
            if (rd_start_pulse) begin
                if (rd_dq.size() != 0) begin
                    rsp_rd_at = cyc + rd_dq.pop_front();
                    rsp_rd_e  = rd_eq.pop_front();
                end else begin
                    rsp_rd_at = cyc + 1;
                    rsp_rd_e  = 2'b00;
                end
            end
            if (wr_start_pulse) begin
                if (wr_dq.size() != 0) begin
                    rsp_wr_at = cyc + wr_dq.pop_front();
                    rsp_wr_e  = wr_eq.pop_front();
                end else begin
                    rsp_wr_at = cyc + 1;
                    rsp_wr_e  = 2'b00;
                end
                // Early read done during the write phase must be ignored.
                if (cur_mode == 3) rsp_noise_at = cyc + 1;
            end
        end
        // Stray done pulses (with error) while idle must be ignored too.
        rd_done_pulse = (cyc == rsp_rd_at) || (cyc == rsp_noise_at) ||
                        (!busy && ($urandom_range(0, 3) == 0));
        rd_error      = (cyc == rsp_rd_at) ? rsp_rd_e : 2'b11;
        wr_done_pulse = (cyc == rsp_wr_at) || (!busy && ($urandom_range(0, 3) == 0));
        wr_error      = (cyc == rsp_wr_at) ? rsp_wr_e : 2'b11;
    end

    // ---------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------
    launch_t mon_l;
    run_t    mon_r;
    bit      cnt_chk = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_start_pulse || wr_start_pulse) begin
                if (exp_l.size() == 0) begin
                    chk("launch_unexpected", {62'd0, rd_start_pulse, wr_start_pulse}, 64'd0);
                end else begin
                    mon_l = exp_l.pop_front();
                    chk("launch_dirs", {62'd0, rd_start_pulse, wr_start_pulse}, {62'd0, mon_l.dirs});
                    chk("launch_cycle", cyc, mon_l.cyc);
                end
            end
            if (cnt_chk) begin
                cnt_chk = 1'b0;
                chk("rd_cycles", rd_cycles, mon_r.rdc);
                chk("wr_cycles", wr_cycles, mon_r.wrc);
                chk("total_cycles", total_cycles, mon_r.tot);
                chk("busy_after_done", busy, 0);
            end
            if (done_pulse) begin
                if (exp_r.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    mon_r = exp_r.pop_front();
                    chk("done_cycle", cyc, mon_r.cyc);
                    chk("status", status, mon_r.st);
                    chk("iter_count", iter_count, mon_r.it);
                    chk("busy_at_done", busy, 1);
                    cnt_chk = 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus + reference model
    // ---------------------------------------------------------------
    function automatic int pick_d(input int fixd);
        return (fixd > 0) ? fixd : int'($urandom_range(1, 12));
    endfunction

    function automatic logic [1:0] pick_e(input bit rnd);
        if (rnd && ($urandom_range(0, 7) == 0)) return 2'($urandom_range(1, 3));
        return 2'b00;
    endfunction

    task automatic flush_all();
        exp_l.delete();
        exp_r.delete();
        rd_dq.delete();
        wr_dq.delete();
        rd_eq.delete();
        wr_eq.delete();
    endtask

    task automatic wait_run_done();
        int b;
        b = 0;
        while (exp_r.size() != 0 && b < 3000) begin
            @(negedge clk);
            b++;
        end
        chk("run_completed", exp_r.size(), 0);
        if (exp_r.size() != 0) flush_all();
        repeat ($urandom_range(2, 5)) @(negedge clk);
    endtask

    // err_it: 1-based iteration whose write done carries error 2'b10.
    task automatic run(input int md, input int rep, input bit rden, input bit wren,
                       input int fixd, input int err_it, input bit rnd, input bit ovl);
        run_t       r;
        launch_t    l;
        int         t0, it_start, n, dr, dw, len;
        logic [1:0] er, ew;
        bit         rl, wl;

        mode       = 2'(md);
        repeat_num = 16'(rep);
        rd_number  = rden ? $urandom_range(1, 1000) : 32'd0;
        wr_number  = wren ? $urandom_range(1, 1000) : 32'd0;
`ifdef PERF_SEQ_TIMEOUT_EN
        timeout_limit = '0;
`else
        timeout_limit = $urandom;
`endif
        cur_mode = md;
        t0 = cyc;
        start_pulse = 1'b1;

        n = (rep == 0) ? 1 : rep;
        it_start = t0 + 1;
        r.st = 5'd0; r.it = 0; r.rdc = 0; r.wrc = 0; r.tot = 0; r.cyc = 0;
        for (int it = 0; it < n; it++) begin
            dr = 0; dw = 0; er = 2'b00; ew = 2'b00;
            case (md)
                0:       begin rl = rden; wl = 1'b0; end
                1:       begin rl = 1'b0; wl = wren; end
                default: begin rl = rden; wl = wren; end
            endcase
            if (rl) begin
                dr = pick_d(fixd);
                er = pick_e(rnd);
                rd_dq.push_back(dr);
                rd_eq.push_back(er);
                r.rdc += dr;
            end
            if (wl) begin
                dw = pick_d(fixd);
                ew = (err_it == it + 1) ? 2'b10 : pick_e(rnd);
                wr_dq.push_back(dw);
                wr_eq.push_back(ew);
                r.wrc += dw;
            end
            if (md == 3 && rl && wl) begin
                l.dirs = 2'b01; l.cyc = it_start;          exp_l.push_back(l);
                l.dirs = 2'b10; l.cyc = it_start + dw + 1; exp_l.push_back(l);
                len = dw + dr + 3;
            end else if (rl || wl) begin
                l.dirs = {rl, wl}; l.cyc = it_start;       exp_l.push_back(l);
                len = ((dr > dw) ? dr : dw) + 2;
            end else begin
                len = 2;
            end
            r.st[1:0] |= er;
            r.st[3:2] |= ew;
            r.it++;
            it_start += len;
            if (r.st[3:0] != 4'd0) break;
        end
        r.cyc = it_start;
        r.tot = it_start - t0;
        exp_r.push_back(r);

        @(negedge clk);
        // Run config must have been latched: scramble it, and optionally
        // retry a start while busy.
        start_pulse = ovl;
        mode        = 2'($urandom);
        repeat_num  = 16'($urandom);
        rd_number   = $urandom_range(0, 1) ? $urandom : 32'd0;
        wr_number   = $urandom_range(0, 1) ? $urandom : 32'd0;
        @(negedge clk);
        start_pulse = 1'b0;
        wait_run_done();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_start"}, rd_start_pulse, 0);
        chk({tag, "_wr_start"}, wr_start_pulse, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done_pulse, 0);
        chk({tag, "_status"}, status, 0);
        chk({tag, "_iter"}, iter_count, 0);
        chk({tag, "_rd_cycles"}, rd_cycles, 0);
        chk({tag, "_wr_cycles"}, wr_cycles, 0);
        chk({tag, "_total"}, total_cycles, 0);
    endtask

    initial begin
        int t0;
        launch_t l;
        run_t    r;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run(0, 1, 1'b0 | 1'b1, 1'b0, 10, 0, 1'b0, 1'b0);  // read only, 10-cycle read
        run(2, 3, 1'b1, 1'b1, 7, 0, 1'b0, 1'b0);          // concurrent, same-cycle dones
        run(3, 1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);          // write then read
        run(3, 2, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0);          // write then read, shortest write
        run(1, 5, 1'b0, 1'b1, 4, 2, 1'b0, 1'b0);          // error abort on iteration 2
        run(0, 2, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);          // skip path + start while busy
        run(2, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);          // skip path, repeat 0
        run(0, 0, 1'b1, 1'b1, 3, 0, 1'b0, 1'b0);          // repeat 0 behaves as 1

        for (int i = 0; i < 40; i++) begin
            run($urandom_range(0, 3), $urandom_range(0, 4),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                0, 0, 1'b1, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a run.
        mode = 2'd2; repeat_num = 16'd3; rd_number = 32'd5; wr_number = 32'd5;
        cur_mode = 2;
        t0 = cyc;
        rd_dq.push_back(8); rd_eq.push_back(2'b00);
        wr_dq.push_back(8); wr_eq.push_back(2'b00);
        l.dirs = 2'b11; l.cyc = t0 + 1; exp_l.push_back(l);
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_before_reset", busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("midrun_reset");
        rst = 1'b0;
        flush_all();
        repeat (20) @(negedge clk);
        chk("idle_after_reset", busy, 0);
        run(3, 2, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0);

`ifdef PERF_SEQ_TIMEOUT_EN
        // Watchdog: read never completes within the limit.
        mode = 2'd0; repeat_num = 16'd1; rd_number = 32'd9; wr_number = 32'd0;
        timeout_limit = 100;
        cur_mode = 0;
        t0 = cyc;
        rd_dq.push_back(300); rd_eq.push_back(2'b00);
        l.dirs = 2'b10; l.cyc = t0 + 1; exp_l.push_back(l);
        r.st = 5'b10000; r.it = 0; r.rdc = 101; r.wrc = 0; r.tot = 103; r.cyc = t0 + 103;
        exp_r.push_back(r);
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        wait_run_done();
        repeat (220) @(negedge clk);
        timeout_limit = '0;
        run(2, 2, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
`endif

        chk("launch_queue_drained", exp_l.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
